wave_capture_buffer: RTL and testbench

Captures 8-bit ADC samples into a ping-pong waveform memory and serves one sample per screen column to the VGA waveform renderer. It sits between the ADC interface and the display stage. The display stage's value_x indexes a column, and this block returns that column's sample on vga_data. Capture is edge-triggered with auto-trigger fallback, and banks swap only on a frame pulse, so the screen never tears.

---
 rtl/wave_pkg.sv | 20 ++
 rtl/wave_dpram.sv | 44 ++++
 rtl/wave_capture_buffer.sv | 190 +++++++++++++++++++
 tb/tb_wave_capture_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and types for the waveform capture buffer.
package wave_pkg;

  // Default samples per capture; one sample per displayed column (max 256).
  localparam int WAVE_DEPTH   = 200;
  // Default sample width.
  localparam int WAVE_DW      = 8;
  // Default number of decimated samples waited before a forced trigger.
  localparam int WAVE_AUTO_TO = 4096;
  // Column address width for the default depth.
  localparam int WAVE_AW      = $clog2(WAVE_DEPTH);

  // Capture state machine encoding.
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_CAP  = 2'd1,
    S_DONE = 2'd2
  } wave_state_t;

endpackage

// File: rtl/wave_dpram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. The read register is cleared whenever the read enable is low, so the
// output is exactly zero for masked reads and after reset.
module wave_dpram
  import wave_pkg::*;
#(
  parameter int AW = WAVE_AW + 1,
  parameter int DW = WAVE_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Storage is left unreset; the caller masks unwritten locations.
  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Write port: store the sample in the write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered data, forced to zero when the read is masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/wave_capture_buffer.sv
// Captures decimated ADC samples into a ping-pong waveform memory after an
// edge trigger (with auto-trigger fallback) and serves one sample per screen
// column to the VGA renderer. Banks swap only on a frame pulse.
module wave_capture_buffer
  import wave_pkg::*;
#(
  parameter int DEPTH   = WAVE_DEPTH,
  parameter int DW      = WAVE_DW,
  parameter int AUTO_TO = WAVE_AUTO_TO
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic [7:0]    decim,
  input  logic          frame_pulse,
  input  logic [10:0]   value_x,
  output logic [DW-1:0] vga_data,
  output logic          armed,
  output logic          capture_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TO - 1);
  localparam logic [10:0]   DEPTH_X   = 11'(DEPTH);

  wave_state_t   state_r;
  logic          bank_sel_r;
  logic          disp_ok_r;
  logic          prev_ok_r;
  logic [DW-1:0] prev_r;
  logic [7:0]    dec_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic [AW-1:0] wr_addr_r;
  logic          armed_r;
  logic          capture_done_r;

  logic          accept_s;
  logic          trig_hit_s;
  logic          fire_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic          re_s;
  logic [AW:0]   raddr_s;

  // Sample acceptance and trigger detection on the incoming sample.
  always_comb begin
    accept_s = adc_valid && (dec_cnt_r == decim);
    if (trig_edge) begin
      trig_hit_s = prev_ok_r && (prev_r > trig_level) && (adc_data <= trig_level);
    end else begin
      trig_hit_s = prev_ok_r && (prev_r < trig_level) && (adc_data >= trig_level);
    end
    fire_s = trig_hit_s || (to_cnt_r == TO_LAST);
  end

  // Write port control: first sample at address 0 on trigger, then sequential.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = '0;
    if (accept_s) begin
      case (state_r)
        S_WAIT: begin
          if (fire_s) begin
            we_s    = 1'b1;
            waddr_s = '0;
          end else begin
            we_s    = 1'b0;
            waddr_s = '0;
          end
        end
        S_CAP: begin
          we_s    = 1'b1;
          waddr_s = wr_addr_r;
        end
        default: begin
          we_s    = 1'b0;
          waddr_s = '0;
        end
      endcase
    end else begin
      we_s    = 1'b0;
      waddr_s = '0;
    end
  end

  // Read port control: display bank is the one not being written.
  always_comb begin
    re_s    = disp_ok_r && (value_x < DEPTH_X);
    raddr_s = {~bank_sel_r, value_x[AW-1:0]};
  end

  // Decimator: keep one of every decim+1 valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_r <= 8'd0;
    end else if (adc_valid) begin
      if (dec_cnt_r == decim) begin
        dec_cnt_r <= 8'd0;
      end else begin
        dec_cnt_r <= dec_cnt_r + 8'd1;
      end
    end else begin
      dec_cnt_r <= dec_cnt_r;
    end
  end

  // Capture FSM with registered status outputs and bank swap on frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_WAIT;
      bank_sel_r     <= 1'b0;
      disp_ok_r      <= 1'b0;
      prev_ok_r      <= 1'b0;
      prev_r         <= '0;
      to_cnt_r       <= '0;
      wr_addr_r      <= '0;
      armed_r        <= 1'b1;
      capture_done_r <= 1'b0;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (accept_s) begin
            prev_r    <= adc_data;
            prev_ok_r <= 1'b1;
            if (fire_s) begin
              wr_addr_r <= AW'(1);
              state_r   <= S_CAP;
              armed_r   <= 1'b0;
            end else begin
              to_cnt_r  <= to_cnt_r + TW'(1);
            end
          end
        end
        S_CAP: begin
          if (accept_s) begin
            if (wr_addr_r == LAST_ADDR) begin
              wr_addr_r      <= '0;
              state_r        <= S_DONE;
              capture_done_r <= 1'b1;
            end else begin
              wr_addr_r <= wr_addr_r + AW'(1);
            end
          end
        end
        S_DONE: begin
          // Swap only here, so a half-written bank is never displayed.
          if (frame_pulse) begin
            bank_sel_r     <= ~bank_sel_r;
            disp_ok_r      <= 1'b1;
            prev_ok_r      <= 1'b0;
            to_cnt_r       <= '0;
            state_r        <= S_WAIT;
            armed_r        <= 1'b1;
            capture_done_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= S_WAIT;
          armed_r        <= 1'b1;
          capture_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Two banks share one RAM; the bank select is the address MSB, so each
  // bank occupies 2**AW words of which the first DEPTH are used.
  wave_dpram #(
    .AW (AW + 1),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr ({bank_sel_r, waddr_s}),
    .wdata (adc_data),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (vga_data)
  );

  assign armed        = armed_r;
  assign capture_done = capture_done_r;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Randomized scoreboard bench for wave_capture_buffer with a queue-based
// reference model of capture, trigger and bank-swap behaviour.
module tb_wave_capture_buffer;

  localparam int DEPTH   = 200;
  localparam int AUTO_TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [7:0]  trig_level;
  logic        trig_edge;
  logic [7:0]  decim;
  logic        frame_pulse;
  logic [10:0] value_x;
  logic [7:0]  vga_data;
  logic        armed;
  logic        capture_done;

  wave_capture_buffer #(.DEPTH(DEPTH), .DW(8), .AUTO_TO(AUTO_TO)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_edge(trig_edge), .decim(decim),
    .frame_pulse(frame_pulse), .value_x(value_x), .vga_data(vga_data),
    .armed(armed), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  vga;
    logic        armed;
    logic        done;
    logic [10:0] x;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state (mode: 0 waiting, 1 capturing, 2 done)
  int         m_mode;
  logic       m_bank_sel;
  logic       m_disp_ok;
  logic       m_prev_ok;
  logic [7:0] m_prev;
  logic [7:0] m_dcnt;
  int         m_tocnt;
  logic [7:0] m_cap[$];
  logic [7:0] m_bank[2][256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bank_sel = 1'b0; m_disp_ok = 1'b0; m_prev_ok = 1'b0;
    m_prev = 8'd0; m_dcnt = 8'd0; m_tocnt = 0; m_cap.delete();
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic fp);
    logic acc;
    logic hit;
    acc = v && (m_dcnt == decim);
    if (v) m_dcnt = acc ? 8'd0 : m_dcnt + 8'd1;
    if (m_mode == 2) begin
      if (fp) begin
        m_bank_sel = ~m_bank_sel; m_disp_ok = 1'b1; m_prev_ok = 1'b0;
        m_tocnt = 0; m_mode = 0;
      end
    end else if (acc) begin
      if (m_mode == 0) begin
        if (trig_edge) hit = m_prev_ok && (m_prev > trig_level) && (d <= trig_level);
        else           hit = m_prev_ok && (m_prev < trig_level) && (d >= trig_level);
        m_prev = d; m_prev_ok = 1'b1;
        if (hit || m_tocnt == AUTO_TO - 1) begin
          m_cap.delete(); m_cap.push_back(d); m_mode = 1;
        end else begin
          m_tocnt++;
        end
      end else begin
        m_cap.push_back(d);
        if (m_cap.size() == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) m_bank[m_bank_sel][i] = m_cap[i];
          m_mode = 2;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input logic v, input logic [7:0] d, input logic fp, input logic [10:0] vx);
    exp_t e;
    adc_valid = v; adc_data = d; frame_pulse = fp; value_x = vx;
    e.x = vx;
    e.vga = (m_disp_ok && vx < DEPTH) ? m_bank[~m_bank_sel][vx[7:0]] : 8'd0;
    model_edge(v, d, fp);
    e.armed = (m_mode == 0);
    e.done  = (m_mode == 2);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic direct_read(input logic [10:0] x, input logic [7:0] exp, input string name);
    step(1'b0, 8'd0, 1'b0, x);
    check(name, vga_data, exp);
  endtask

  task automatic swap();
    step(1'b0, 8'd0, 1'b1, 11'($urandom_range(700)));
  endtask

  task automatic sweep();
    for (int x = 0; x < DEPTH + 10; x++) step(1'b0, 8'd0, 1'b0, 11'(x));
    step(1'b0, 8'd0, 1'b0, 11'd256);
    step(1'b0, 8'd0, 1'b0, 11'd639);
    step(1'b0, 8'd0, 1'b0, 11'd2047);
  endtask

  // kind: 0 up-ramp, 1 down-ramp, 2 constant, 3 random data
  task automatic run_capture(input int kind, input logic [7:0] start, input int gap,
                             input bit mid_pulse, input bit coinc, input bit rnd_pulse,
                             input int reset_at);
    logic [7:0] val;
    logic       v;
    logic       fp;
    logic [7:0] d;
    val = start;
    for (int c = 0; c < 20000; c++) begin
      if (m_mode == 2) break;
      if (reset_at > 0 && m_mode == 1 && m_cap.size() == reset_at) begin
        adc_valid = 1'b0; frame_pulse = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_vga", vga_data, 8'd0);
        check("reset_armed", armed, 1'b1);
        check("reset_done", capture_done, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        return;
      end
      v  = ($urandom_range(99) >= gap);
      fp = 1'b0;
      if (mid_pulse && m_mode == 1 && m_cap.size() == 50) fp = 1'b1;
      if (coinc && m_mode == 1 && m_cap.size() == DEPTH - 1 && v && m_dcnt == decim) fp = 1'b1;
      if (rnd_pulse && $urandom_range(99) < 5) fp = 1'b1;
      d = (kind == 3) ? 8'($urandom) : val;
      step(v, d, fp, 11'($urandom_range(700)));
      if (v) begin
        if (kind == 0) val = val + 8'd1;
        else if (kind == 1) val = val - 8'd1;
      end
    end
  endtask

  // Monitor: compare DUT outputs one tick after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("vga_x%0d", e.x), vga_data, e.vga);
        check("armed", armed, e.armed);
        check("capture_done", capture_done, e.done);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized captures.
  initial begin
    rst_n = 1'b0; adc_data = 8'd0; adc_valid = 1'b0; trig_level = 8'd128;
    trig_edge = 1'b0; decim = 8'd0; frame_pulse = 1'b0; value_x = 11'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_armed", armed, 1'b1);
    check("rst_done", capture_done, 1'b0);
    check("rst_vga", vga_data, 8'd0);
    direct_read(11'd0, 8'd0, "pre_swap_col0");
    direct_read(11'd199, 8'd0, "pre_swap_col199");

    // Rising trigger on an up-ramp crossing 128
    trig_level = 8'd128; trig_edge = 1'b0; decim = 8'd0;
    run_capture(0, 8'd120, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 8'd0, 1'b0, 11'd0);
    swap();
    direct_read(11'd0, 8'd128, "rise_col0");
    direct_read(11'd199, 8'd71, "rise_col199");
    direct_read(11'd200, 8'd0, "rise_col200");
    sweep();

    // Falling trigger; frame pulses during capture and on the last write
    trig_level = 8'd100; trig_edge = 1'b1;
    run_capture(1, 8'd108, 0, 1'b1, 1'b1, 1'b0, 0);
    direct_read(11'd0, 8'd128, "no_swap_col0");
    swap();
    direct_read(11'd0, 8'd100, "fall_col0");
    direct_read(11'd1, 8'd99, "fall_col1");
    sweep();

    // Decimation by 4 with gaps in adc_valid
    trig_level = 8'd128; trig_edge = 1'b0; decim = 8'd3;
    run_capture(0, 8'd100, 30, 1'b0, 1'b0, 1'b0, 0);
    swap();
    direct_read(11'd0, 8'd131, "decim_col0");
    direct_read(11'd1, 8'd135, "decim_col1");
    direct_read(11'd199, 8'd159, "decim_col199");
    sweep();

    // Auto-trigger on a constant input
    decim = 8'd0;
    run_capture(2, 8'd50, 0, 1'b0, 1'b0, 1'b0, 0);
    swap();
    direct_read(11'd0, 8'd50, "auto_col0");
    direct_read(11'd199, 8'd50, "auto_col199");

    // Reset mid-capture, then a fresh capture into bank 0
    run_capture(3, 8'd0, 0, 1'b0, 1'b0, 1'b0, 100);
    direct_read(11'd5, 8'd0, "post_reset_col5");
    trig_level = 8'd210; trig_edge = 1'b0; decim = 8'd0;
    run_capture(0, 8'd200, 0, 1'b0, 1'b0, 1'b0, 0);
    swap();
    direct_read(11'd0, 8'd210, "after_reset_col0");
    sweep();

    // Randomized captures
    for (int k = 0; k < 4; k++) begin
      trig_level = 8'($urandom);
      trig_edge  = 1'($urandom_range(1));
      decim      = 8'($urandom_range(3));
      run_capture($urandom_range(3), 8'($urandom), $urandom_range(50), 1'b0, 1'b0, 1'b1, 0);
      repeat ($urandom_range(5)) step(1'b0, 8'd0, 1'b0, 11'($urandom_range(700)));
      swap();
      sweep();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
